matrix_result_drain: RTL and testbench
======================================

Name: matrix_result_drain

Overview:
Drains the 4x4 result matrix of the matrix MAC unit and serialises it as a 16-beat valid/ready stream in row-major order.
- On a capture request, the whole matrix is snapshotted into an internal buffer in a single cycle. The MAC may then clear and accumulate again while the drain streams the buffer out.
- Sits between the MAC result port and the downstream writeback/egress logic.

Parameters:
DATA_WIDTH, 8, width of one matrix element and of out_data.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
clear  input  1  synchronous abort: return to IDLE and clear overrun.
capture  input  1  request to snapshot result_flat and start a stream.
result_flat  input  16*DATA_WIDTH  MAC result; element (r,c) at bits [(r*4+c)*DATA_WIDTH +: DATA_WIDTH].
busy  output  1  high while a stream is pending or in progress.
out_valid  output  1  stream beat valid.
out_ready  input  1  downstream accepts the beat.
out_data  output  DATA_WIDTH  element value.
out_row  output  2  row index of the current beat.
out_col  output  2  column index of the current beat.
out_last  output  1  high on the beat for (3,3).
done  output  1  one-cycle pulse after the final handshake.
overrun  output  1  sticky: a capture was rejected while busy.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0 immediately. State=IDLE, index=0, buffer contents don't-care. This holds mid-stream too; no partial beats survive.
- Handshake: a beat transfers on a rising edge where out_valid=1 and out_ready=1.
- States: IDLE, STREAM.
- IDLE:
  - capture=1 at edge N: buffer <= result_flat, index <= 0, state <= STREAM.
  - After edge N: busy=1, out_valid=1, out_data=element(0,0). Latency from capture to first valid beat is 1 cycle.
- STREAM:
  - out_data = buffer[index]; out_row = index[3:2]; out_col = index[1:0]; out_last = (index==15).
  - Each handshake increments index.
  - While out_valid=1 and out_ready=0: out_data, out_row, out_col and out_last hold stable, and out_valid stays high.
- Final handshake (index 15):
  - Next cycle: out_valid=0, busy=0, state=IDLE, done=1 for exactly one cycle.
- Capture in the same cycle as the final handshake: accepted back-to-back.
  - Next cycle: new snapshot loaded, index=0, out_valid stays 1, busy stays 1, done still pulses.
- Capture in STREAM at any other time: ignored, buffer unchanged, overrun <= 1 (sticky).
- clear=1: state <= IDLE, index <= 0, out_valid/busy <= 0, overrun <= 0, done <= 0.
  - clear beats capture when both are high in the same cycle; that capture is dropped and does not set overrun.
  - clear during the final handshake: the beat still counts as transferred downstream, but done is not pulsed.
- Snapshot isolation: result_flat changes after the capture edge do not affect streamed data.
- out_ready is ignored while out_valid=0. No combinational path from out_ready to out_valid.
- Throughput: 16 cycles per matrix with out_ready held high. Back-to-back matrices have zero bubble cycles.

Test Plan:
- Basic drain: result_flat element(r,c)=r*4+c+1; pulse capture; out_ready=1 → 16 beats with data 1..16 on consecutive cycles, rows/cols 0..3 row-major, out_last only on data=16, done pulses 1 cycle later, busy low after.
- Backpressure: same matrix, out_ready toggling 1,0,0,1,…; change result_flat to all 0xFF after capture → data sequence is still 1..16, beats stay stable while stalled, done appears after the 16th handshake.
- Overrun: capture at beat 5, then clear → stream unaffected until clear; overrun=1 from the cycle after the rejected capture; clear drops out_valid, busy and overrun to 0 next cycle.
- Back-to-back: second matrix with all elements 0xA5; capture asserted on the cycle of the final handshake → 32 contiguous beats, the last 16 all 0xA5, no bubble, overrun stays 0, done pulses after beat 16 and again after beat 32.
- Async reset mid-stream: assert reset=0 between edges at beat 7 → out_valid, busy, out_last, done and overrun go 0 without a clock edge; after release, a new capture streams from (0,0).
- Clear vs capture collision: clear=1 and capture=1 in the same IDLE cycle → no stream starts, busy=0, overrun=0.

Source files
------------

// File: rtl/matrix_result_drain.sv
// Snapshots a 4x4 MAC result matrix and streams it out row-major as a
// 16-beat valid/ready stream, accepting a new capture on the final beat.
module matrix_result_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    capture,
  input  logic [16*DATA_WIDTH-1:0] result_flat,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_row,
  output logic [1:0]              out_col,
  output logic                    out_last,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state;
  logic [3:0]              index;
  logic [16*DATA_WIDTH-1:0] snapshot;
  logic                    handshake;
  logic                    final_beat;
  logic                    load;

  always_comb begin
    handshake  = out_valid && out_ready;
    final_beat = handshake && (index == 4'd15);
    load       = capture && !clear && ((state == IDLE) || final_beat);
  end

  // Snapshot has no reset: its contents only matter once a stream is running.
  always_ff @(posedge clock) begin
    if (load) snapshot <= result_flat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        index     <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (capture) begin
              state     <= STREAM;
              index     <= '0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
          STREAM: begin
            if (capture && !final_beat) overrun <= 1'b1;
            if (final_beat) begin
              done  <= 1'b1;
              index <= '0;
              // A capture on the final beat restarts without leaving STREAM.
              if (!capture) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
              end
            end else if (handshake) begin
              index <= index + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    out_data = out_valid ? snapshot[int'(index)*DATA_WIDTH +: DATA_WIDTH] : '0;
    out_row  = index[3:2];
    out_col  = index[1:0];
    out_last = out_valid && (index == 4'd15);
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Randomized and directed bench for matrix_result_drain against a
// queue-based model of the pending beats.
module tb_matrix_result_drain;

  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            clear;
  logic            capture;
  logic [16*DW-1:0] result_flat;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_row;
  logic [1:0]      out_col;
  logic            out_last;
  logic            done;
  logic            overrun;

  matrix_result_drain #(.DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .capture     (capture),
    .result_flat (result_flat),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_last    (out_last),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: beats still owed downstream, plus the done/overrun flags.
  logic [DW-1:0] mq[$];
  bit            m_done;
  bit            m_ovr;

  logic [16*DW-1:0] incr_flat;
  logic [16*DW-1:0] ff_flat;
  logic [16*DW-1:0] a5_flat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int unsigned idx;
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("busy", 32'(busy), 32'(mq.size() != 0));
    check("done", 32'(done), 32'(m_done));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (mq.size() != 0) begin
      idx = 16 - mq.size();
      check("data", 32'(out_data), 32'(mq[0]));
      check("row", 32'(out_row), idx / 4);
      check("col", 32'(out_col), idx % 4);
      check("last", 32'(out_last), 32'(mq.size() == 1));
    end else begin
      check("last_idle", 32'(out_last), 32'd0);
    end
  endtask

  // Called at a negedge: check, drive, advance one edge, update model.
  task automatic step(input bit cap, input bit clr, input bit rdy, input logic [16*DW-1:0] flat);
    bit hs;
    bit fin;
    compare_outputs();
    capture     = cap;
    clear       = clr;
    out_ready   = rdy;
    result_flat = flat;
    @(posedge clock);
    hs  = (mq.size() != 0) && rdy;
    fin = hs && (mq.size() == 1);
    m_done = 1'b0;
    if (clr) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      if (hs) void'(mq.pop_front());
      if (fin) m_done = 1'b1;
      if (cap) begin
        if (mq.size() == 0) begin
          for (int i = 0; i < 16; i++) mq.push_back(flat[i*DW +: DW]);
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      incr_flat[i*DW +: DW] = DW'(i + 1);
      ff_flat[i*DW +: DW]   = 8'hFF;
      a5_flat[i*DW +: DW]   = 8'hA5;
    end
    reset = 1'b0; clear = 1'b0; capture = 1'b0; out_ready = 1'b0;
    result_flat = '0;
    m_done = 1'b0; m_ovr = 1'b0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Basic drain
    step(1, 0, 1, incr_flat);
    for (int i = 0; i < 18; i++) step(0, 0, 1, incr_flat);

    // Backpressure with result_flat changed after the capture
    step(1, 0, 0, incr_flat);
    for (int i = 0; i < 70; i++) step(0, 0, (i % 3) == 0, ff_flat);
    step(0, 0, 1, '0);

    // Overrun at beat 5, then clear
    step(1, 0, 1, incr_flat);
    for (int i = 0; i < 5; i++) step(0, 0, 1, incr_flat);
    step(1, 0, 1, a5_flat);
    step(0, 0, 1, a5_flat);
    step(0, 1, 1, a5_flat);
    step(0, 0, 1, a5_flat);

    // Back-to-back: capture on the final handshake
    step(1, 0, 1, incr_flat);
    for (int i = 0; i < 40; i++) step(mq.size() == 1 && i < 20, 0, 1, a5_flat);

    // Async reset mid-stream, after a rejected capture
    step(1, 0, 1, incr_flat);
    step(0, 0, 1, incr_flat);
    step(1, 0, 1, ff_flat);
    for (int i = 0; i < 4; i++) step(0, 0, 1, incr_flat);
    compare_outputs();
    capture = 1'b0; clear = 1'b0; out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_row", 32'(out_row), 32'd0);
    check("arst_col", 32'(out_col), 32'd0);
    mq.delete(); m_done = 1'b0; m_ovr = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    step(1, 0, 1, a5_flat);
    for (int i = 0; i < 17; i++) step(0, 0, 1, incr_flat);

    // Clear and capture together in IDLE
    step(1, 1, 1, incr_flat);
    step(0, 0, 1, incr_flat);
    step(0, 0, 1, incr_flat);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(5) == 0, $urandom_range(49) == 0, $urandom_range(3) != 0,
           {$urandom, $urandom, $urandom, $urandom});
    end
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
